periph_xbar: RTL and testbench
==============================

// Module: periph_xbar
// PURPOSE
//  TL-UL crossbar joining the two core hosts (instruction fetch IF, load/store LSU) to twelve SoC
//  devices: ICCM, DCCM, GPIO, LDO1, LDO2, DCDC, PLL1, TSEN1, TSEN2, DAP, PLIC, UART.
//  Decodes the A-channel address, arbitrates per device and routes D-channel responses to the
//  issuing host. Unmapped addresses get a TL-UL error response.
// PARAMETERS
//  NumHosts    2   fixed host count (0=IF, 1=LSU)
//  NumDevices  12  fixed device count, order as in PURPOSE
// PORTS
//  clk_i                  in   1       single clock; all state on rising edge
//  rst_i                  in   1       reset, synchronous, active-high
//  tl_if_i / tl_if_o      in/out tl_h2d_t/tl_d2h_t   IF host request / response
//  tl_lsu_i / tl_lsu_o    in/out tl_h2d_t/tl_d2h_t   LSU host request / response
//  tl_<dev>_o / tl_<dev>_i out/in tl_h2d_t/tl_d2h_t  per device:
//      <dev> = iccm dccm gpio ldo1 ldo2 dcdc pll1 tsen1 tsen2 dap plic uart
// BEHAVIOUR
//  Address map (xbar_pkg ADDR_SPACE_x / ADDR_MASK_x). Hit: (a_address & ~MASK) == BASE.
//   ICCM 0x0000_0000/0xFFFF   DCCM 0x0001_0000/0xFFFF   GPIO 0x4000_0000/0xFFF
//   LDO1 0x4000_1000  LDO2 0x4000_2000  DCDC 0x4000_3000  PLL1 0x4000_4000
//   TSEN1 0x4000_5000  TSEN2 0x4000_6000  DAP 0x4000_7000  UART 0x4000_8000  (all mask 0xFFF)
//   PLIC 0x4100_0000/0xFFFF. No other address hits; a miss selects the error responder.
//  A channel: combinational, zero latency. Selected device sees a_valid and every A field
//   unmodified in the same cycle as host a_valid. Host a_ready = selected device a_ready AND grant.
//   Unselected devices: a_valid=0, all other fields 0.
//  Per-host state: one outstanding transaction. After A handshake the host is busy: a_ready=0
//   until its D handshake completes. Latch target index (4b, value 12 = error responder).
//  Per-device arbiter: fixed priority, LSU > IF. Device locked to the granted host from A handshake
//   until device D handshake (d_valid & d_ready). No new grant while locked.
//  D channel: device d_* forwarded combinationally to the owner host; device d_ready = owner
//   d_ready. Non-owner hosts see d_valid=0. Non-owned devices see d_ready=0.
//  Error responder: accepts any unmapped request immediately (a_ready=1 when idle). d_valid asserts
//   on the next cycle with d_error=1, d_data=0, d_size/d_source echoed. d_opcode=AccessAckData for
//   Get, AccessAck for Put. Held until host d_ready. Each host has its own responder.
//  Host idle (no a_valid): tl_*_o = TL_D2H_DEFAULT with a_ready=1.
//  Reset (rst_i=1): all locks, busy flags and responders cleared. All device a_valid=0, all host
//   d_valid=0 from the next edge. In-flight transactions are dropped; a late device d_valid after
//   reset is ignored (no owner).
//  Same cycle, both hosts, same device: LSU granted, IF waits (a_ready=0). IF is granted on the
//   cycle after the LSU D handshake.
//  Same cycle, different devices: both proceed in parallel.
//  D handshake and a new A request in the same cycle from one host: the new request is not
//   accepted until the next cycle.
// STRUCTURE
//  xbar_pkg: ADDR_SPACE_*, ADDR_MASK_*, device index enum, NumDevices.
//  tlul_pkg (existing): tl_h2d_t, tl_d2h_t, opcodes, *_DEFAULT.
//  One sub-module: xbar_err_resp (per-host error responder). Decode, arbitration and muxing are
//   inline generate loops.
// TESTING
//  1 LSU Put 0x4000_5000, data 0xFFFF_FFFF, mask 0xF, held:
//    tl_tsen1_o.a_valid=1 same cycle, fields equal; other device a_valid=0.
//  2 IF Get 0x0000_0100, ICCM a_ready=1, d_valid 2 cycles later with data 0x1234:
//    tl_if_o.d_data=0x1234, d_valid, no LSU response.
//  3 IF and LSU both Get DCCM same cycle: DCCM sees LSU first.
//    IF serviced after LSU D handshake; responses routed to the correct hosts.
//  4 LSU Get 0x5000_0000 (unmapped): next cycle d_valid=1, d_error=1,
//    d_opcode=AccessAckData; no device a_valid.
//  5 IF→GPIO and LSU→UART same cycle: both a_valid=1 together, independent responses.
//  6 rst_i=1 mid-transaction (device lock held): next cycle all host d_valid=0, device a_valid=0;
//    new request works after release.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by the crossbar and its hosts/devices.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{d_ready: 1'b1, default: '0};
  localparam tl_d2h_t TL_D2H_DEFAULT = '{a_ready: 1'b1, default: '0};

endpackage

// File: rtl/xbar_pkg.sv
// Peripheral crossbar address map and device indexing.
package xbar_pkg;

  localparam int NumDevices = 12;
  // Target index used for any address that hits no device.
  localparam logic [3:0] ErrIdx = 4'd12;

  typedef enum logic [3:0] {
    DevIccm, DevDccm, DevGpio, DevLdo1, DevLdo2, DevDcdc,
    DevPll1, DevTsen1, DevTsen2, DevDap, DevPlic, DevUart
  } dev_e;

  localparam logic [31:0] ADDR_SPACE_ICCM  = 32'h0000_0000;
  localparam logic [31:0] ADDR_SPACE_DCCM  = 32'h0001_0000;
  localparam logic [31:0] ADDR_SPACE_GPIO  = 32'h4000_0000;
  localparam logic [31:0] ADDR_SPACE_LDO1  = 32'h4000_1000;
  localparam logic [31:0] ADDR_SPACE_LDO2  = 32'h4000_2000;
  localparam logic [31:0] ADDR_SPACE_DCDC  = 32'h4000_3000;
  localparam logic [31:0] ADDR_SPACE_PLL1  = 32'h4000_4000;
  localparam logic [31:0] ADDR_SPACE_TSEN1 = 32'h4000_5000;
  localparam logic [31:0] ADDR_SPACE_TSEN2 = 32'h4000_6000;
  localparam logic [31:0] ADDR_SPACE_DAP   = 32'h4000_7000;
  localparam logic [31:0] ADDR_SPACE_PLIC  = 32'h4100_0000;
  localparam logic [31:0] ADDR_SPACE_UART  = 32'h4000_8000;

  localparam logic [31:0] ADDR_MASK_ICCM  = 32'h0000_FFFF;
  localparam logic [31:0] ADDR_MASK_DCCM  = 32'h0000_FFFF;
  localparam logic [31:0] ADDR_MASK_GPIO  = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_LDO1  = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_LDO2  = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_DCDC  = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_PLL1  = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_TSEN1 = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_TSEN2 = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_DAP   = 32'h0000_0FFF;
  localparam logic [31:0] ADDR_MASK_PLIC  = 32'h0000_FFFF;
  localparam logic [31:0] ADDR_MASK_UART  = 32'h0000_0FFF;

  localparam logic [NumDevices-1:0][31:0] AddrSpace = {
    ADDR_SPACE_UART, ADDR_SPACE_PLIC, ADDR_SPACE_DAP, ADDR_SPACE_TSEN2,
    ADDR_SPACE_TSEN1, ADDR_SPACE_PLL1, ADDR_SPACE_DCDC, ADDR_SPACE_LDO2,
    ADDR_SPACE_LDO1, ADDR_SPACE_GPIO, ADDR_SPACE_DCCM, ADDR_SPACE_ICCM
  };
  localparam logic [NumDevices-1:0][31:0] AddrMask = {
    ADDR_MASK_UART, ADDR_MASK_PLIC, ADDR_MASK_DAP, ADDR_MASK_TSEN2,
    ADDR_MASK_TSEN1, ADDR_MASK_PLL1, ADDR_MASK_DCDC, ADDR_MASK_LDO2,
    ADDR_MASK_LDO1, ADDR_MASK_GPIO, ADDR_MASK_DCCM, ADDR_MASK_ICCM
  };

  function automatic logic [3:0] addr_decode(input logic [31:0] addr);
    addr_decode = ErrIdx;
    for (int i = 0; i < NumDevices; i++) begin
      if ((addr & ~AddrMask[i]) == AddrSpace[i]) addr_decode = 4'(i);
    end
  endfunction

endpackage

// File: rtl/xbar_err_resp.sv
// Per-host responder for unmapped addresses: accepts at once, answers
// with d_error on the following cycle and holds until the host takes it.
module xbar_err_resp
  import tlul_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_valid,
  input  logic [2:0] a_opcode,
  input  logic [1:0] a_size,
  input  logic [7:0] a_source,
  input  logic       d_ready,
  output tl_d2h_t    rsp
);

  logic       pend;
  logic [2:0] op;
  logic [1:0] size;
  logic [7:0] source;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= 1'b0;
    end else if (!pend && a_valid) begin
      pend   <= 1'b1;
      op     <= (a_opcode == Get) ? AccessAckData : AccessAck;
      size   <= a_size;
      source <= a_source;
    end else if (pend && d_ready) begin
      pend <= 1'b0;
    end
  end

  always_comb begin
    rsp          = '0;
    rsp.a_ready  = ~pend;
    rsp.d_valid  = pend;
    rsp.d_error  = pend;
    rsp.d_opcode = op;
    rsp.d_size   = size;
    rsp.d_source = source;
  end

endmodule

// File: rtl/periph_xbar.sv
// Two-host (IF, LSU) to twelve-device TL-UL crossbar with per-device
// fixed-priority arbitration and one outstanding transaction per host.
module periph_xbar
  import tlul_pkg::*;
  import xbar_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_if_i,
  output tl_d2h_t tl_if_o,
  input  tl_h2d_t tl_lsu_i,
  output tl_d2h_t tl_lsu_o,
  output tl_h2d_t tl_iccm_o,
  input  tl_d2h_t tl_iccm_i,
  output tl_h2d_t tl_dccm_o,
  input  tl_d2h_t tl_dccm_i,
  output tl_h2d_t tl_gpio_o,
  input  tl_d2h_t tl_gpio_i,
  output tl_h2d_t tl_ldo1_o,
  input  tl_d2h_t tl_ldo1_i,
  output tl_h2d_t tl_ldo2_o,
  input  tl_d2h_t tl_ldo2_i,
  output tl_h2d_t tl_dcdc_o,
  input  tl_d2h_t tl_dcdc_i,
  output tl_h2d_t tl_pll1_o,
  input  tl_d2h_t tl_pll1_i,
  output tl_h2d_t tl_tsen1_o,
  input  tl_d2h_t tl_tsen1_i,
  output tl_h2d_t tl_tsen2_o,
  input  tl_d2h_t tl_tsen2_i,
  output tl_h2d_t tl_dap_o,
  input  tl_d2h_t tl_dap_i,
  output tl_h2d_t tl_plic_o,
  input  tl_d2h_t tl_plic_i,
  output tl_h2d_t tl_uart_o,
  input  tl_d2h_t tl_uart_i
);

  localparam int NumHosts = 2;

  tl_h2d_t [NumHosts-1:0]              h_req;
  tl_d2h_t [NumHosts-1:0]              h_rsp;
  tl_h2d_t [NumDevices-1:0]            d_req;
  tl_d2h_t [NumDevices-1:0]            d_rsp;
  logic    [NumHosts-1:0][3:0]         sel;
  logic    [NumHosts-1:0]              busy;
  logic    [NumDevices-1:0][NumHosts-1:0] gnt;

  assign h_req[0] = tl_if_i;
  assign h_req[1] = tl_lsu_i;
  assign tl_if_o  = h_rsp[0];
  assign tl_lsu_o = h_rsp[1];

  assign tl_iccm_o  = d_req[DevIccm];   assign d_rsp[DevIccm]  = tl_iccm_i;
  assign tl_dccm_o  = d_req[DevDccm];   assign d_rsp[DevDccm]  = tl_dccm_i;
  assign tl_gpio_o  = d_req[DevGpio];   assign d_rsp[DevGpio]  = tl_gpio_i;
  assign tl_ldo1_o  = d_req[DevLdo1];   assign d_rsp[DevLdo1]  = tl_ldo1_i;
  assign tl_ldo2_o  = d_req[DevLdo2];   assign d_rsp[DevLdo2]  = tl_ldo2_i;
  assign tl_dcdc_o  = d_req[DevDcdc];   assign d_rsp[DevDcdc]  = tl_dcdc_i;
  assign tl_pll1_o  = d_req[DevPll1];   assign d_rsp[DevPll1]  = tl_pll1_i;
  assign tl_tsen1_o = d_req[DevTsen1];  assign d_rsp[DevTsen1] = tl_tsen1_i;
  assign tl_tsen2_o = d_req[DevTsen2];  assign d_rsp[DevTsen2] = tl_tsen2_i;
  assign tl_dap_o   = d_req[DevDap];    assign d_rsp[DevDap]   = tl_dap_i;
  assign tl_plic_o  = d_req[DevPlic];   assign d_rsp[DevPlic]  = tl_plic_i;
  assign tl_uart_o  = d_req[DevUart];   assign d_rsp[DevUart]  = tl_uart_i;

  for (genvar d = 0; d < NumDevices; d++) begin : g_dev
    logic [NumHosts-1:0] req;
    logic                locked;
    logic                owner;
    tl_h2d_t             fwd;

    for (genvar h = 0; h < NumHosts; h++) begin : g_req
      assign req[h] = h_req[h].a_valid & ~busy[h] & (sel[h] == 4'(d));
    end

    // LSU wins ties; a locked device grants nobody until its D handshake.
    assign gnt[d][1] = ~locked & req[1];
    assign gnt[d][0] = ~locked & req[0] & ~req[1];

    always_comb begin
      fwd = '0;
      if (gnt[d][1])      fwd = h_req[1];
      else if (gnt[d][0]) fwd = h_req[0];
      fwd.d_ready = locked & h_req[owner].d_ready;
    end
    assign d_req[d] = fwd;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        locked <= 1'b0;
        owner  <= 1'b0;
      end else if (|gnt[d] && d_rsp[d].a_ready) begin
        locked <= 1'b1;
        owner  <= gnt[d][1];
      end else if (locked && d_rsp[d].d_valid && fwd.d_ready) begin
        locked <= 1'b0;
      end
    end
  end

  for (genvar h = 0; h < NumHosts; h++) begin : g_host
    logic       bsy;
    logic [3:0] tgt;
    logic       miss;
    tl_d2h_t    rsp;
    tl_d2h_t    err;

    assign sel[h]  = addr_decode(h_req[h].a_address);
    assign miss    = (sel[h] == ErrIdx);
    assign busy[h] = bsy;

    xbar_err_resp u_err (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .a_valid  (h_req[h].a_valid & ~bsy & miss),
      .a_opcode (h_req[h].a_opcode),
      .a_size   (h_req[h].a_size),
      .a_source (h_req[h].a_source),
      .d_ready  (h_req[h].d_ready),
      .rsp      (err)
    );

    always_comb begin
      rsp = TL_D2H_DEFAULT;
      if (bsy) begin
        rsp = (tgt == ErrIdx) ? err : d_rsp[tgt];
        rsp.a_ready = 1'b0;
      end else if (h_req[h].a_valid) begin
        rsp = '0;
        rsp.a_ready = miss ? err.a_ready : (d_rsp[sel[h]].a_ready & gnt[sel[h]][h]);
      end
    end
    assign h_rsp[h] = rsp;

    // Busy blocks new A traffic until the D handshake, including its own cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        bsy <= 1'b0;
        tgt <= '0;
      end else if (!bsy && h_req[h].a_valid && rsp.a_ready) begin
        bsy <= 1'b1;
        tgt <= sel[h];
      end else if (bsy && rsp.d_valid && h_req[h].d_ready) begin
        bsy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_periph_xbar.sv
// Directed scenarios plus random traffic, all checked each cycle against a
// transaction-level model of the crossbar.
module tb_periph_xbar;
  import tlul_pkg::*;
  import xbar_pkg::*;

  localparam int ND = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_h2d_t hin  [2];
  tl_d2h_t hout [2];
  tl_d2h_t din  [ND];
  tl_h2d_t dout [ND];
  tl_d2h_t if_o, lsu_o;
  tl_h2d_t o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11;

  assign hout[0] = if_o;  assign hout[1] = lsu_o;
  assign dout[0] = o0;    assign dout[1] = o1;    assign dout[2]  = o2;   assign dout[3]  = o3;
  assign dout[4] = o4;    assign dout[5] = o5;    assign dout[6]  = o6;   assign dout[7]  = o7;
  assign dout[8] = o8;    assign dout[9] = o9;    assign dout[10] = o10;  assign dout[11] = o11;

  periph_xbar dut (
    .clk_i(clk), .rst_i(rst),
    .tl_if_i(hin[0]),   .tl_if_o(if_o),
    .tl_lsu_i(hin[1]),  .tl_lsu_o(lsu_o),
    .tl_iccm_o(o0),     .tl_iccm_i(din[0]),
    .tl_dccm_o(o1),     .tl_dccm_i(din[1]),
    .tl_gpio_o(o2),     .tl_gpio_i(din[2]),
    .tl_ldo1_o(o3),     .tl_ldo1_i(din[3]),
    .tl_ldo2_o(o4),     .tl_ldo2_i(din[4]),
    .tl_dcdc_o(o5),     .tl_dcdc_i(din[5]),
    .tl_pll1_o(o6),     .tl_pll1_i(din[6]),
    .tl_tsen1_o(o7),    .tl_tsen1_i(din[7]),
    .tl_tsen2_o(o8),    .tl_tsen2_i(din[8]),
    .tl_dap_o(o9),      .tl_dap_i(din[9]),
    .tl_plic_o(o10),    .tl_plic_i(din[10]),
    .tl_uart_o(o11),    .tl_uart_i(din[11])
  );

  // Model: each host holds at most one open transaction; a device is owned
  // by whichever host has an open transaction to it.
  typedef struct {
    bit         act;
    int         dev;
    logic [2:0] eop;
    logic [1:0] esz;
    logic [7:0] esrc;
  } txn_t;
  txn_t mh [2];

  int unsigned base [ND] = '{32'h0, 32'h10000, 32'h40000000, 32'h40001000, 32'h40002000,
                             32'h40003000, 32'h40004000, 32'h40005000, 32'h40006000,
                             32'h40007000, 32'h41000000, 32'h40008000};
  int unsigned span [ND] = '{32'h10000, 32'h10000, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                             32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h10000, 32'h1000};

  int total = 0;
  int bad   = 0;

  function automatic int m_decode(logic [31:0] a);
    for (int i = 0; i < ND; i++)
      if (a >= base[i] && (a - base[i]) < span[i]) return i;
    return ND;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    chk(nm, 128'(act), 128'(exp));
  endtask

  function automatic int nvalid();
    int n = 0;
    for (int d = 0; d < ND; d++) n += int'(dout[d].a_valid);
    return n;
  endfunction

  task automatic model_step();
    int      s [2];
    int      own [ND];
    int      g [ND];
    tl_h2d_t ed;
    tl_d2h_t eh;
    for (int h = 0; h < 2; h++) s[h] = m_decode(hin[h].a_address);
    for (int d = 0; d < ND; d++) begin
      own[d] = -1;
      g[d]   = -1;
      for (int h = 0; h < 2; h++) if (mh[h].act && mh[h].dev == d) own[d] = h;
      if (own[d] < 0) begin
        if (hin[1].a_valid && !mh[1].act && s[1] == d)      g[d] = 1;
        else if (hin[0].a_valid && !mh[0].act && s[0] == d) g[d] = 0;
      end
      ed = '0;
      if (g[d] >= 0) begin
        ed = hin[g[d]];
        ed.a_valid = 1'b1;
        ed.d_ready = 1'b0;
      end else if (own[d] >= 0) begin
        ed.d_ready = hin[own[d]].d_ready;
      end
      chk($sformatf("dev%0d_out", d), 128'(dout[d]), 128'(ed));
    end
    for (int h = 0; h < 2; h++) begin
      if (mh[h].act) begin
        if (mh[h].dev == ND) begin
          eh = '0;
          eh.d_valid  = 1'b1;
          eh.d_error  = 1'b1;
          eh.d_opcode = mh[h].eop;
          eh.d_size   = mh[h].esz;
          eh.d_source = mh[h].esrc;
        end else begin
          eh = din[mh[h].dev];
          eh.a_ready = 1'b0;
        end
      end else if (hin[h].a_valid) begin
        eh = '0;
        eh.a_ready = (s[h] == ND) ? 1'b1 : ((g[s[h]] == h) && din[s[h]].a_ready);
      end else begin
        eh = TL_D2H_DEFAULT;
      end
      chk($sformatf("host%0d_out", h), 128'(hout[h]), 128'(eh));
      if (mh[h].act) begin
        if (eh.d_valid && hin[h].d_ready) mh[h].act = 1'b0;
      end else if (hin[h].a_valid && eh.a_ready) begin
        mh[h].act  = 1'b1;
        mh[h].dev  = s[h];
        mh[h].eop  = (hin[h].a_opcode == 3'h4) ? 3'h1 : 3'h0;
        mh[h].esz  = hin[h].a_size;
        mh[h].esrc = hin[h].a_source;
      end
    end
    if (rst) begin
      mh[0].act = 1'b0;
      mh[1].act = 1'b0;
    end
  endtask

  task automatic settle(); #4; model_step(); endtask
  task automatic adv();    @(posedge clk); #1; endtask
  task automatic cyc();    settle(); adv(); endtask

  function automatic tl_h2d_t mkreq(logic [2:0] op, logic [31:0] addr, logic [31:0] data, logic [7:0] src);
    tl_h2d_t r = TL_H2D_DEFAULT;
    r.a_valid = 1'b1;  r.a_opcode = op;  r.a_size = 2'd2;  r.a_source = src;
    r.a_address = addr; r.a_mask = 4'hF; r.a_data = data;
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    int          picks [6] = '{0, 1, 7, 11, 2, 10};
    logic [31:0] miss  [4] = '{32'h50000000, 32'h00020000, 32'h40009000, 32'h41010000};
    int k = int'($urandom_range(0, 9));
    if (k < 6) return base[picks[k]] + ($urandom % span[picks[k]]);
    return miss[k - 6] | 32'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [2:0] ops [3] = '{3'h0, 3'h1, 3'h4};
    for (int h = 0; h < 2; h++) hin[h] = TL_H2D_DEFAULT;
    for (int d = 0; d < ND; d++) begin din[d] = '0; din[d].a_ready = 1'b1; end
    adv(); adv();
    settle();
    lit("rst_if_a_ready", 32'(hout[0].a_ready), 1);
    lit("rst_dev_avalid", nvalid(), 0);
    adv();
    rst = 1'b0;

    // 1: LSU Put to TSEN1 forwarded unchanged, same cycle
    hin[1] = mkreq(3'h0, 32'h40005000, 32'hFFFFFFFF, 8'd3);
    settle();
    lit("t1_tsen1_valid", 32'(dout[7].a_valid), 1);
    lit("t1_tsen1_addr", dout[7].a_address, 32'h40005000);
    lit("t1_tsen1_data", dout[7].a_data, 32'hFFFFFFFF);
    lit("t1_tsen1_mask", 32'(dout[7].a_mask), 32'hF);
    lit("t1_only_one", nvalid(), 1);
    adv();
    hin[1].a_valid = 1'b0;
    din[7].d_valid = 1'b1; din[7].d_source = 8'd3;
    settle();
    lit("t1_lsu_dvalid", 32'(hout[1].d_valid), 1);
    lit("t1_if_dvalid", 32'(hout[0].d_valid), 0);
    adv();
    din[7].d_valid = 1'b0;

    // 2: IF Get ICCM, response two cycles later
    hin[0] = mkreq(3'h4, 32'h00000100, 32'h0, 8'd1);
    settle();
    lit("t2_iccm_valid", 32'(dout[0].a_valid), 1);
    adv();
    hin[0].a_valid = 1'b0;
    cyc();
    din[0].d_valid = 1'b1; din[0].d_data = 32'h1234; din[0].d_opcode = 3'h1;
    settle();
    lit("t2_if_data", hout[0].d_data, 32'h1234);
    lit("t2_if_dvalid", 32'(hout[0].d_valid), 1);
    lit("t2_lsu_dvalid", 32'(hout[1].d_valid), 0);
    adv();
    din[0].d_valid = 1'b0;

    // 3: DCCM contention, LSU first, IF after LSU D handshake
    hin[0] = mkreq(3'h4, 32'h00010000, 32'h0, 8'd1);
    hin[1] = mkreq(3'h4, 32'h00010004, 32'h0, 8'd2);
    settle();
    lit("t3_dccm_addr", dout[1].a_address, 32'h00010004);
    lit("t3_if_wait", 32'(hout[0].a_ready), 0);
    lit("t3_lsu_ready", 32'(hout[1].a_ready), 1);
    adv();
    hin[1].a_valid = 1'b0;
    settle();
    lit("t3_if_locked", 32'(hout[0].a_ready), 0);
    adv();
    din[1].d_valid = 1'b1; din[1].d_data = 32'hAAAA; din[1].d_opcode = 3'h1;
    settle();
    lit("t3_lsu_data", hout[1].d_data, 32'hAAAA);
    lit("t3_if_nod", 32'(hout[0].d_valid), 0);
    adv();
    din[1].d_valid = 1'b0;
    settle();
    lit("t3_if_grant", dout[1].a_address, 32'h00010000);
    lit("t3_if_ready", 32'(hout[0].a_ready), 1);
    adv();
    hin[0].a_valid = 1'b0;
    din[1].d_valid = 1'b1; din[1].d_data = 32'hBBBB;
    settle();
    lit("t3_if_data", hout[0].d_data, 32'hBBBB);
    lit("t3_lsu_nod", 32'(hout[1].d_valid), 0);
    adv();
    din[1].d_valid = 1'b0;

    // 4: unmapped address answered by the error responder
    hin[1] = mkreq(3'h4, 32'h50000000, 32'h0, 8'd5);
    hin[1].d_ready = 1'b0;
    settle();
    lit("t4_ready", 32'(hout[1].a_ready), 1);
    lit("t4_nodev", nvalid(), 0);
    adv();
    hin[1].a_valid = 1'b0;
    settle();
    lit("t4_dvalid", 32'(hout[1].d_valid), 1);
    lit("t4_derror", 32'(hout[1].d_error), 1);
    lit("t4_opcode", 32'(hout[1].d_opcode), 1);
    lit("t4_source", 32'(hout[1].d_source), 5);
    lit("t4_data", hout[1].d_data, 0);
    adv();
    settle();
    lit("t4_held", 32'(hout[1].d_valid), 1);
    adv();
    hin[1].d_ready = 1'b1;
    cyc();
    settle();
    lit("t4_done", 32'(hout[1].d_valid), 0);
    adv();

    // 5: parallel IF->GPIO and LSU->UART
    hin[0] = mkreq(3'h0, 32'h40000010, 32'h55, 8'd1);
    hin[1] = mkreq(3'h4, 32'h40008000, 32'h0, 8'd2);
    settle();
    lit("t5_gpio_valid", 32'(dout[2].a_valid), 1);
    lit("t5_uart_valid", 32'(dout[11].a_valid), 1);
    lit("t5_both_ready", 32'(hout[0].a_ready & hout[1].a_ready), 1);
    adv();
    hin[0].a_valid = 1'b0; hin[1].a_valid = 1'b0;
    din[2].d_valid = 1'b1;  din[2].d_data = 32'h11;
    din[11].d_valid = 1'b1; din[11].d_data = 32'h22;
    settle();
    lit("t5_if_data", hout[0].d_data, 32'h11);
    lit("t5_lsu_data", hout[1].d_data, 32'h22);
    adv();
    din[2].d_valid = 1'b0; din[11].d_valid = 1'b0;

    // 6: reset with PLL1 locked, late device response ignored
    hin[1] = mkreq(3'h4, 32'h40004010, 32'h0, 8'd4);
    settle();
    lit("t6_acc", 32'(hout[1].a_ready), 1);
    adv();
    hin[1].a_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    din[6].d_valid = 1'b1;
    settle();
    lit("t6_lsu_nod", 32'(hout[1].d_valid), 0);
    lit("t6_if_nod", 32'(hout[0].d_valid), 0);
    lit("t6_dev_noready", 32'(dout[6].d_ready), 0);
    lit("t6_nodev", nvalid(), 0);
    adv();
    din[6].d_valid = 1'b0;
    hin[1].a_valid = 1'b1;
    settle();
    lit("t6_new_valid", 32'(dout[6].a_valid), 1);
    lit("t6_new_ready", 32'(hout[1].a_ready), 1);
    adv();
    hin[1].a_valid = 1'b0;
    din[6].d_valid = 1'b1;
    settle();
    lit("t6_resp", 32'(hout[1].d_valid), 1);
    adv();
    din[6].d_valid = 1'b0;
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int h = 0; h < 2; h++) begin
        hin[h].a_valid   = ($urandom_range(0, 9) < 6);
        hin[h].a_opcode  = ops[$urandom_range(0, 2)];
        hin[h].a_param   = 3'($urandom);
        hin[h].a_size    = 2'($urandom);
        hin[h].a_source  = 8'($urandom);
        hin[h].a_address = rand_addr();
        hin[h].a_mask    = 4'($urandom);
        hin[h].a_data    = $urandom;
        hin[h].d_ready   = ($urandom_range(0, 9) < 7);
      end
      for (int d = 0; d < ND; d++) begin
        din[d].a_ready  = ($urandom_range(0, 9) < 7);
        din[d].d_valid  = ($urandom_range(0, 1) == 1);
        din[d].d_opcode = 3'($urandom);
        din[d].d_param  = 3'($urandom);
        din[d].d_size   = 2'($urandom);
        din[d].d_source = 8'($urandom);
        din[d].d_sink   = 1'($urandom);
        din[d].d_data   = $urandom;
        din[d].d_error  = 1'($urandom);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
